// File: rtl/bank_pkg.sv
// Shared definitions for the bank host responder: opcodes, status codes,
// responder FSM states and the PIN failure limit used by the optional lockout.
package bank_pkg;

    localparam int MAX_FAILS  = 3;
    localparam int FAIL_WIDTH = 2;

    typedef enum logic [1:0] {
        OP_AUTH     = 2'b00,
        OP_BALANCE  = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_WITHDRAW = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_OK       = 3'b000,
        ST_BAD_PSW  = 3'b001,
        ST_NO_FUNDS = 3'b010,
        ST_OVERFLOW = 3'b011,
        ST_LOCKED   = 3'b100
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_EXEC,
        S_RESP
    } state_e;

endpackage

// File: rtl/account_store.sv
// Per-card account storage (balance, PIN, failure count) with one registered
// read port and one write port. Failure counters exist only with LOCKOUT_EN.
module account_store
    import bank_pkg::*;
#(
    parameter int password_width = 4,
    parameter int balance_width  = 20,
    parameter int card_width     = 3,
    parameter int init_balance   = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [card_width-1:0]     rd_card,
    output logic [balance_width-1:0]  rd_balance,
    output logic [password_width-1:0] rd_password,
`ifdef LOCKOUT_EN
    output logic [FAIL_WIDTH-1:0]     rd_fails,
    input  logic [FAIL_WIDTH-1:0]     wr_fails,
`endif
    input  logic                      wr_en,
    input  logic [card_width-1:0]     wr_card,
    input  logic [balance_width-1:0]  wr_balance
);

    localparam int ACCOUNTS = 1 << card_width;

    logic [balance_width-1:0]  balance_mem  [ACCOUNTS];
    logic [password_width-1:0] password_mem [ACCOUNTS];
`ifdef LOCKOUT_EN
    logic [FAIL_WIDTH-1:0]     fails_mem    [ACCOUNTS];
`endif

    // Contents must be reloaded by reset, so storage is registers, not RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ACCOUNTS; i++) begin
                balance_mem[i]  <= balance_width'(init_balance);
                password_mem[i] <= password_width'(i + 1);
`ifdef LOCKOUT_EN
                fails_mem[i]    <= '0;
`endif
            end
        end else if (wr_en) begin
            balance_mem[wr_card] <= wr_balance;
`ifdef LOCKOUT_EN
            fails_mem[wr_card]   <= wr_fails;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_balance  <= '0;
            rd_password <= '0;
`ifdef LOCKOUT_EN
            rd_fails    <= '0;
`endif
        end else if (rd_en) begin
            rd_balance  <= balance_mem[rd_card];
            rd_password <= password_mem[rd_card];
`ifdef LOCKOUT_EN
            rd_fails    <= fails_mem[rd_card];
`endif
        end
    end

endmodule

// File: rtl/bank_host_responder.sv
// ATM request responder: IDLE -> LOOKUP -> EXEC -> RESP per request.
// Define LOCKOUT_EN to lock a card after MAX_FAILS consecutive bad PINs.
module bank_host_responder
    import bank_pkg::*;
#(
    parameter int password_width = 4,
    parameter int balance_width  = 20,
    parameter int card_width     = 3,
    parameter int init_balance   = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [card_width-1:0]     req_card,
    input  logic [password_width-1:0] req_password,
    input  logic [balance_width-1:0]  req_value,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [2:0]                resp_status,
    output logic [balance_width-1:0]  resp_balance
);

    state_e                    state_reg, state_next;
    op_e                       op_reg;
    logic [card_width-1:0]     card_reg;
    logic [password_width-1:0] password_reg;
    logic [balance_width-1:0]  value_reg;
    logic [2:0]                resp_status_reg;
    logic [balance_width-1:0]  resp_balance_reg;

    logic                      rd_en, wr_en, write_needed, locked;
    logic [balance_width-1:0]  rd_balance, exec_balance;
    logic [password_width-1:0] rd_password;
    logic [balance_width:0]    sum;
    status_e                   exec_status;
`ifdef LOCKOUT_EN
    logic [FAIL_WIDTH-1:0]     rd_fails, exec_fails;
`endif

    account_store #(
        .password_width (password_width),
        .balance_width  (balance_width),
        .card_width     (card_width),
        .init_balance   (init_balance)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_card     (card_reg),
        .rd_balance  (rd_balance),
        .rd_password (rd_password),
`ifdef LOCKOUT_EN
        .rd_fails    (rd_fails),
        .wr_fails    (exec_fails),
`endif
        .wr_en       (wr_en),
        .wr_card     (card_reg),
        .wr_balance  (exec_balance)
    );

    // Operation result, valid while in EXEC (read data arrived from LOOKUP).
    always_comb begin
        sum          = {1'b0, rd_balance} + {1'b0, value_reg};
        exec_status  = ST_OK;
        exec_balance = rd_balance;
        locked       = 1'b0;
`ifdef LOCKOUT_EN
        exec_fails   = rd_fails;
        locked       = (rd_fails == FAIL_WIDTH'(MAX_FAILS));
`endif
        if (locked) begin
            exec_status = ST_LOCKED;
        end else if (password_reg != rd_password) begin
            exec_status = ST_BAD_PSW;
`ifdef LOCKOUT_EN
            exec_fails  = rd_fails + 1'b1;
`endif
        end else begin
`ifdef LOCKOUT_EN
            exec_fails = '0;
`endif
            case (op_reg)
                OP_DEPOSIT: begin
                    if (sum[balance_width]) exec_status = ST_OVERFLOW;
                    else                    exec_balance = sum[balance_width-1:0];
                end
                OP_WITHDRAW: begin
                    if (value_reg > rd_balance) exec_status = ST_NO_FUNDS;
                    else                        exec_balance = rd_balance - value_reg;
                end
                default: ;
            endcase
        end
        write_needed = (exec_balance != rd_balance);
`ifdef LOCKOUT_EN
        write_needed = write_needed || (exec_fails != rd_fails);
`endif
    end

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            S_IDLE:   if (req_valid) state_next = S_LOOKUP;
            S_LOOKUP: begin
                rd_en      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                wr_en      = write_needed;
                state_next = S_RESP;
            end
            S_RESP:   if (resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg           <= OP_AUTH;
            card_reg         <= '0;
            password_reg     <= '0;
            value_reg        <= '0;
            resp_status_reg  <= '0;
            resp_balance_reg <= '0;
        end else begin
            if (state_reg == S_IDLE && req_valid) begin
                op_reg       <= op_e'(req_op);
                card_reg     <= req_card;
                password_reg <= req_password;
                value_reg    <= req_value;
            end
            if (state_reg == S_EXEC) begin
                resp_status_reg  <= exec_status;
                resp_balance_reg <= exec_balance;
            end
        end
    end

    assign req_ready    = (state_reg == S_IDLE);
    assign resp_valid   = (state_reg == S_RESP);
    assign resp_status  = resp_status_reg;
    assign resp_balance = resp_balance_reg;

endmodule

// File: tb/tb_bank_host_responder.sv
// Directed self-checking bench for bank_host_responder; expectations follow
// LOCKOUT_EN when the bench is compiled with it.
module tb_bank_host_responder;

    localparam int PW = 4;
    localparam int BW = 20;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [CW-1:0] req_card;
    logic [PW-1:0] req_password;
    logic [BW-1:0] req_value;
    logic          resp_valid;
    logic          resp_ready;
    logic [2:0]    resp_status;
    logic [BW-1:0] resp_balance;

    int pass_count  = 0;
    int check_count = 0;

    logic [2:0]    got_status;
    logic [BW-1:0] got_balance;
    int            got_lat;

    bank_host_responder #(
        .password_width (PW),
        .balance_width  (BW),
        .card_width     (CW),
        .init_balance   (1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_card     (req_card),
        .req_password (req_password),
        .req_value    (req_value),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_status  (resp_status),
        .resp_balance (resp_balance)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One request/response; lat counts cycles from the handshake cycle (T) to resp_valid.
    task automatic do_req(input logic [1:0] op, input logic [CW-1:0] card,
                          input logic [PW-1:0] pw, input logic [BW-1:0] value,
                          output logic [2:0] status, output logic [BW-1:0] balance,
                          output int lat);
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = op;
        req_card     = card;
        req_password = pw;
        req_value    = value;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        status  = resp_status;
        balance = resp_balance;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        $display("txn op=%0d card=%0d pin=%0d value=%0d -> status=%0d balance=%0d latency=%0d",
                 op, card, pw, value, status, balance, lat);
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        req_valid    = 1'b0;
        resp_ready   = 1'b0;
        req_op       = 2'b00;
        req_card     = '0;
        req_password = '0;
        req_value    = '0;
        #12;
        check_count++;
        if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid);
        else pass_count++;
        check_count++;
        if (resp_status !== 3'd0) $display("FAIL reset_status got %0d want 0", resp_status);
        else pass_count++;
        check_count++;
        if (resp_balance !== 20'd0) $display("FAIL reset_balance got %0d want 0", resp_balance);
        else pass_count++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready);
        else pass_count++;
    endtask

    task automatic test_balance_latency();
        do_req(2'b01, 3'd2, 4'd3, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0) $display("FAIL balance_status got %0d want 0", got_status);
        else pass_count++;
        check_count++;
        if (got_balance !== 20'd1000) $display("FAIL balance_value got %0d want 1000", got_balance);
        else pass_count++;
        check_count++;
        if (got_lat != 3) $display("FAIL balance_latency got %0d want 3", got_lat);
        else pass_count++;
    endtask

    task automatic test_deposit_withdraw();
        do_req(2'b10, 3'd0, 4'd1, 20'd500, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd1500)
            $display("FAIL deposit_500 got %0d/%0d want 0/1500", got_status, got_balance);
        else pass_count++;
        do_req(2'b11, 3'd0, 4'd1, 20'd1500, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd0)
            $display("FAIL withdraw_all got %0d/%0d want 0/0", got_status, got_balance);
        else pass_count++;
        do_req(2'b10, 3'd0, 4'd1, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd0)
            $display("FAIL deposit_zero got %0d/%0d want 0/0", got_status, got_balance);
        else pass_count++;
    endtask

    task automatic test_no_funds_overflow();
        do_req(2'b11, 3'd1, 4'd2, 20'd1001, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd2 || got_balance !== 20'd1000)
            $display("FAIL no_funds got %0d/%0d want 2/1000", got_status, got_balance);
        else pass_count++;
        do_req(2'b10, 3'd1, 4'd2, 20'd1048000, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd3 || got_balance !== 20'd1000)
            $display("FAIL overflow got %0d/%0d want 3/1000", got_status, got_balance);
        else pass_count++;
        do_req(2'b11, 3'd1, 4'd2, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd1000)
            $display("FAIL withdraw_zero got %0d/%0d want 0/1000", got_status, got_balance);
        else pass_count++;
        do_req(2'b10, 3'd7, 4'd8, 20'd1047575, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd1048575)
            $display("FAIL deposit_to_max got %0d/%0d want 0/1048575", got_status, got_balance);
        else pass_count++;
        do_req(2'b10, 3'd7, 4'd8, 20'd1, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd3 || got_balance !== 20'd1048575)
            $display("FAIL overflow_by_one got %0d/%0d want 3/1048575", got_status, got_balance);
        else pass_count++;
    endtask

    task automatic test_bad_pin();
        do_req(2'b10, 3'd6, 4'd0, 20'd5, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd1 || got_balance !== 20'd1000)
            $display("FAIL bad_pin_deposit got %0d/%0d want 1/1000", got_status, got_balance);
        else pass_count++;
        do_req(2'b00, 3'd6, 4'd7, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd1000)
            $display("FAIL good_pin_auth got %0d/%0d want 0/1000", got_status, got_balance);
        else pass_count++;
    endtask

    task automatic test_lockout();
        logic [2:0] exp_fourth;
`ifdef LOCKOUT_EN
        exp_fourth = 3'd4;
`else
        exp_fourth = 3'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            do_req(2'b00, 3'd5, 4'd0, 20'd0, got_status, got_balance, got_lat);
            check_count++;
            if (got_status !== 3'd1 || got_balance !== 20'd1000)
                $display("FAIL lockout_bad_%0d got %0d/%0d want 1/1000", i, got_status, got_balance);
            else pass_count++;
        end
        do_req(2'b00, 3'd5, 4'd6, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== exp_fourth || got_balance !== 20'd1000)
            $display("FAIL lockout_fourth got %0d/%0d want %0d/1000", got_status, got_balance, exp_fourth);
        else pass_count++;
    endtask

    task automatic test_stall();
        int waited;
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = 2'b01;
        req_card     = 3'd3;
        req_password = 4'd4;
        req_value    = 20'd0;
        @(posedge clk);
        #1;
        // Keep a deposit offered during the stall; it must not be accepted.
        req_op    = 2'b10;
        req_value = 20'd9;
        waited = 0;
        while (resp_valid !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        for (int c = 0; c < 10; c++) begin
            check_count++;
            if (resp_valid !== 1'b1 || resp_status !== 3'd0 || resp_balance !== 20'd1000 || req_ready !== 1'b0)
                $display("FAIL stall_cycle_%0d got valid=%b status=%0d balance=%0d ready=%b want 1/0/1000/0",
                         c, resp_valid, resp_status, resp_balance, req_ready);
            else pass_count++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_count++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL stall_release got valid=%b ready=%b want 0/1", resp_valid, req_ready);
        else pass_count++;
        $display("txn stalled BALANCE card=3 released after 10 cycles");
        do_req(2'b01, 3'd3, 4'd4, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd1000)
            $display("FAIL stall_ignored_req got %0d/%0d want 0/1000", got_status, got_balance);
        else pass_count++;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = 2'b10;
        req_card     = 3'd4;
        req_password = 4'd5;
        req_value    = 20'd100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_count++;
        if (resp_valid !== 1'b0 || resp_status !== 3'd0 || resp_balance !== 20'd0)
            $display("FAIL abort_immediate got valid=%b status=%0d balance=%0d want 0/0/0",
                     resp_valid, resp_status, resp_balance);
        else pass_count++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL abort_release got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        else pass_count++;
        $display("txn DEPOSIT card=4 aborted by reset");
        do_req(2'b01, 3'd4, 4'd5, 20'd0, got_status, got_balance, got_lat);
        check_count++;
        if (got_status !== 3'd0 || got_balance !== 20'd1000)
            $display("FAIL abort_balance got %0d/%0d want 0/1000", got_status, got_balance);
        else pass_count++;
    endtask

    initial begin
        test_reset();
        test_balance_latency();
        test_deposit_withdraw();
        test_no_funds_overflow();
        test_bad_pin();
        test_lockout();
        test_stall();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/bank_host_responder.md
BANK_HOST_RESPONDER -- requirements
Module: bank_host_responder

Interface
REQ-001 The block SHALL have parameter password_width, default 4, meaning PIN width in bits.
REQ-002 The block SHALL have parameter balance_width, default 20, meaning account balance and transaction value width.
REQ-003 The block SHALL have parameter card_width, default 3, meaning card index width; accounts = 2**card_width.
REQ-004 The block SHALL have parameter init_balance, default 1000, meaning per-account balance loaded at reset.
REQ-005 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid  input  1  ATM request present.
REQ-008 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-009 The block SHALL have port req_op  input  2  opcode: 00 AUTH, 01 BALANCE, 10 DEPOSIT, 11 WITHDRAW.
REQ-010 The block SHALL have port req_card  input  card_width  card index.
REQ-011 The block SHALL have port req_password  input  password_width  PIN entered.
REQ-012 The block SHALL have port req_value  input  balance_width  transaction amount.
REQ-013 The block SHALL have port resp_valid  output  1  response present.
REQ-014 The block SHALL have port resp_ready  input  1  ATM accepts response.
REQ-015 The block SHALL have port resp_status  output  3  status: 000 OK, 001 BAD_PSW, 010 NO_FUNDS, 011 OVERFLOW, 100 LOCKED.
REQ-016 The block SHALL have port resp_balance  output  balance_width  account balance after the operation.

Function
REQ-017 The FSM SHALL have states IDLE, LOOKUP, EXEC, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A handshake in cycle T (req_valid && req_ready) SHALL capture all req_* fields and move to LOOKUP at T+1.
REQ-019 LOOKUP SHALL read the addressed account; EXEC SHALL compute status and write back; resp_valid SHALL rise at T+3.
REQ-020 In RESP, resp_valid, resp_status and resp_balance SHALL hold stable until resp_ready=1, then return to IDLE next cycle.
REQ-021 resp_ready asserted outside RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored.
REQ-022 Status priority SHALL be LOCKED, then BAD_PSW, then op-specific.
REQ-023 On PIN mismatch, status SHALL be BAD_PSW, the balance SHALL be unchanged, and that card's failure count SHALL increment, saturating at 3.
REQ-024 On PIN match, that card's failure count SHALL clear.
REQ-025 AUTH and BALANCE SHALL return OK with the current balance and no write.
REQ-026 DEPOSIT SHALL compute the sum at balance_width+1 bits; a carry SHALL give OVERFLOW with the balance unchanged, otherwise OK with the balance updated.
REQ-027 WITHDRAW with value > balance SHALL give NO_FUNDS with the balance unchanged; otherwise OK with balance-value (value==balance yields 0).
REQ-028 A value of 0 SHALL return OK with no change for DEPOSIT and WITHDRAW.
REQ-029 resp_balance SHALL always report the post-operation stored balance, including on non-OK status.

Reset
REQ-030 Reset (rst=0) SHALL force IDLE, resp_valid=0, resp_status=000 and resp_balance=0 immediately, regardless of the clock.
REQ-031 Reset SHALL load every account with balance init_balance, PIN = card index + 1, and failure count 0.
REQ-032 Reset mid-transaction SHALL abort it with no account write and no response.
REQ-033 Deassertion of rst SHALL give req_ready=1 at the first rising edge after release.

Configuration
REQ-034 With LOCKOUT_EN defined, a card whose failure count reaches 3 SHALL return LOCKED for every request until reset, including requests with the correct PIN.
REQ-035 Without LOCKOUT_EN, the failure counters SHALL be omitted and LOCKED SHALL never be returned.

Structure
REQ-036 The shared package bank_pkg SHALL hold the opcode constants, status codes, FSM state encoding, and MAX_FAILS=3.
REQ-037 Account storage (balance, PIN, failure count per card, one read port and one write port) SHALL be the sub-module account_store.

Verification
REQ-038 Reset, then BALANCE card 2 PIN 3 -> OK, balance 1000, resp_valid exactly 3 cycles after the handshake.
REQ-039 DEPOSIT card 0 PIN 1 value 500, then WITHDRAW 1500 -> OK 1500, then OK 0.
REQ-040 WITHDRAW card 1 PIN 2 value 1001 -> NO_FUNDS, balance 1000; DEPOSIT 1048000 -> OVERFLOW, balance 1000.
REQ-041 With LOCKOUT_EN, three AUTH card 5 PIN 0, then AUTH PIN 6 -> BAD_PSW x3, then LOCKED; without LOCKOUT_EN the fourth request -> OK.
REQ-042 Hold resp_ready=0 for 10 cycles -> response stable and req_ready=0; assert rst during EXEC of a DEPOSIT -> balance remains 1000 afterwards.
